// File: rtl/bure_pkg.sv
// Shared BureCore definitions: stage-register state encoding, the default
// payload widths carried across each pipeline boundary, and a small helper
// that turns a stage-register state into its entry count.
package bure_pkg;

  // Entries held by a stage register: none, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    SKID  = 2'd2
  } bure_stage_state_e;

  // Default payload widths for each stage boundary.
  localparam int unsigned IF_ID_PAYLOAD_W  = 64;
  localparam int unsigned ID_EX_PAYLOAD_W  = 128;
  localparam int unsigned EX_MEM_PAYLOAD_W = 96;
  localparam int unsigned MEM_WB_PAYLOAD_W = 72;
  localparam int unsigned BURE_ADDR_W      = 32;

  // Number of entries held in a given state.
  function automatic logic [1:0] stage_occupancy(input bure_stage_state_e st);
    case (st)
      EMPTY:   return 2'd0;
      MAIN:    return 2'd1;
      SKID:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bure_sat_counter.sv
// Saturating up-counter with synchronous clear. Used for the stage stall
// counter and available for general performance counting.
module bure_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise step until all-ones and then hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/bure_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid
// entry, flush for redirects, and a saturating stall counter.
//
// Handshake: a beat moves when valid and ready are both high in the same
// cycle; valid never drops without a transfer (except flush/reset), and
// the offered data stays stable while valid is high and ready is low.
// With SKID_EN=1 up_ready is a register and never depends on dn_ready; with
// SKID_EN=0 it is !main_valid || dn_ready.
module bure_stage_reg
  import bure_pkg::*;
#(
  parameter int unsigned PAYLOAD_W  = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter bit          SKID_EN    = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [PAYLOAD_W-1:0]  up_data,
  input  logic [ADDR_WIDTH-1:0] up_addr,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [PAYLOAD_W-1:0]  dn_data,
  output logic [ADDR_WIDTH-1:0] dn_addr,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  bure_stage_state_e     state_q, state_d;
  logic                  up_ready_q, up_ready_d;
  logic [PAYLOAD_W-1:0]  m_data_q, m_data_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [PAYLOAD_W-1:0]  s_data_q, s_data_d;
  logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
  logic                  up_xfer;
  logic                  dn_xfer;

  assign dn_valid  = (state_q != EMPTY);
  assign dn_data   = m_data_q;
  assign dn_addr   = m_addr_q;
  assign occupancy = stage_occupancy(state_q);
  assign up_ready  = SKID_EN ? up_ready_q : ((state_q == EMPTY) || dn_ready);
  assign up_xfer   = up_valid && up_ready;
  assign dn_xfer   = dn_valid && dn_ready;

  // Next state and register loads; flush overrides everything at the end.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_addr_d = m_addr_q;
    s_data_d = s_data_q;
    s_addr_d = s_addr_q;
    case (state_q)
      EMPTY: begin
        if (up_xfer) begin
          state_d  = MAIN;
          m_data_d = up_data;
          m_addr_d = up_addr;
        end
      end
      MAIN: begin
        if (up_xfer && dn_xfer) begin
          m_data_d = up_data;
          m_addr_d = up_addr;
        end else if (up_xfer) begin
          // Only reachable with a skid entry; pass-through mode accepts
          // into a full main register only when it is draining.
          if (SKID_EN) begin
            state_d  = SKID;
            s_data_d = up_data;
            s_addr_d = up_addr;
          end
        end else if (dn_xfer) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        // up_ready is low here, so only the drain can happen.
        if (dn_xfer) begin
          state_d  = MAIN;
          m_data_d = s_data_q;
          m_addr_d = s_addr_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
    up_ready_d = (state_d != SKID);
  end

  // Control state register; only valid/state bits are reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      up_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      up_ready_q <= up_ready_d;
    end
  end

  // Payload and address storage, left unreset.
  always_ff @(posedge clk) begin
    m_data_q <= m_data_d;
    m_addr_q <= m_addr_d;
    s_data_q <= s_data_d;
    s_addr_q <= s_addr_d;
  end

  // Stall cycles: presented but not consumed. Flush does not touch it.
  bure_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (dn_valid && !dn_ready),
    .clr (1'b0),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_bure_stage_reg.sv
// Bench for bure_stage_reg: one skid instance (4-bit counter) and one
// pass-through instance share the same stimulus. A queue model of each is
// checked on every falling edge, and hand-computed literals pin key points.
module tb_bure_stage_reg;

  localparam int PW    = 64;
  localparam int AW    = 32;
  localparam int EW    = PW + AW;
  localparam int S_MAX = 15;
  localparam int P_MAX = 65535;

  // Clock and shared inputs
  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          up_valid;
  logic [PW-1:0] up_data;
  logic [AW-1:0] up_addr;
  logic          dn_ready;

  always #5 clk = ~clk;

  // Skid instance outputs
  logic          s_up_ready, s_dn_valid;
  logic [PW-1:0] s_dn_data;
  logic [AW-1:0] s_dn_addr;
  logic [1:0]    s_occ;
  logic [3:0]    s_stall;

  // Pass-through instance outputs
  logic          p_up_ready, p_dn_valid;
  logic [PW-1:0] p_dn_data;
  logic [AW-1:0] p_dn_addr;
  logic [1:0]    p_occ;
  logic [15:0]   p_stall;

  bure_stage_reg #(
    .PAYLOAD_W (PW), .ADDR_WIDTH (AW), .SKID_EN (1'b1), .CNT_W (4)
  ) u_skid (
    .clk (clk), .rst (rst), .flush (flush),
    .up_valid (up_valid), .up_ready (s_up_ready),
    .up_data (up_data), .up_addr (up_addr),
    .dn_valid (s_dn_valid), .dn_ready (dn_ready),
    .dn_data (s_dn_data), .dn_addr (s_dn_addr),
    .occupancy (s_occ), .stall_cnt (s_stall)
  );

  bure_stage_reg #(
    .PAYLOAD_W (PW), .ADDR_WIDTH (AW), .SKID_EN (1'b0), .CNT_W (16)
  ) u_pass (
    .clk (clk), .rst (rst), .flush (flush),
    .up_valid (up_valid), .up_ready (p_up_ready),
    .up_data (up_data), .up_addr (up_addr),
    .dn_valid (p_dn_valid), .dn_ready (dn_ready),
    .dn_data (p_dn_data), .dn_addr (p_dn_addr),
    .occupancy (p_occ), .stall_cnt (p_stall)
  );

  // Scoreboard state
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  logic [EW-1:0] q_s[$];
  logic [EW-1:0] q_p[$];
  int          cnt_s = 0;
  int          cnt_p = 0;

  task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: each instance is a FIFO of capacity 2 (skid) or 1 (pass).
  always @(posedge clk) begin
    bit urs, dxs, urp, dxp;
    if (rst) begin
      q_s.delete();
      q_p.delete();
      cnt_s = 0;
      cnt_p = 0;
    end else begin
      urs = (q_s.size() < 2);
      dxs = (q_s.size() != 0) && dn_ready;
      urp = (q_p.size() == 0) || dn_ready;
      dxp = (q_p.size() != 0) && dn_ready;
      if (q_s.size() != 0 && !dn_ready && cnt_s < S_MAX) cnt_s++;
      if (q_p.size() != 0 && !dn_ready && cnt_p < P_MAX) cnt_p++;
      if (flush) begin
        q_s.delete();
        q_p.delete();
      end else begin
        if (dxs) void'(q_s.pop_front());
        if (up_valid && urs) q_s.push_back({up_addr, up_data});
        if (dxp) void'(q_p.pop_front());
        if (up_valid && urp) q_p.push_back({up_addr, up_data});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s.dn_valid", s_dn_valid, q_s.size() != 0);
      chk("s.occupancy", s_occ, q_s.size());
      chk("s.up_ready", s_up_ready, q_s.size() < 2);
      chk("s.stall_cnt", s_stall, cnt_s);
      if (q_s.size() != 0) begin
        chk("s.dn_addr", s_dn_addr, q_s[0][EW-1:PW]);
        chk("s.dn_data", s_dn_data, q_s[0][PW-1:0]);
      end
      chk("p.dn_valid", p_dn_valid, q_p.size() != 0);
      chk("p.occupancy", p_occ, q_p.size());
      chk("p.up_ready", p_up_ready, (q_p.size() == 0) || dn_ready);
      chk("p.stall_cnt", p_stall, cnt_p);
      if (q_p.size() != 0) begin
        chk("p.dn_addr", p_dn_addr, q_p[0][EW-1:PW]);
        chk("p.dn_data", p_dn_data, q_p[0][PW-1:0]);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic r);
    up_valid = v;
    up_addr  = a;
    up_data  = {~a, a};
    dn_ready = r;
    tick();
  endtask

  // Directed stimulus with literal expectations
  initial begin
    logic [AW-1:0] a;
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_addr = '0; up_data = '0; dn_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst.s.dn_valid", s_dn_valid, 0);
    chk("rst.s.occupancy", s_occ, 0);
    chk("rst.s.stall_cnt", s_stall, 0);
    chk("rst.s.up_ready", s_up_ready, 1);
    chk("rst.p.up_ready", p_up_ready, 1);

    // Streaming: each address appears the cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      a = AW'(4 * i);
      drive(1'b1, a, 1'b1);
      chk("stream.s.dn_addr", s_dn_addr, a);
      chk("stream.p.dn_addr", p_dn_addr, a);
    end
    chk("stream.s.stall_cnt", s_stall, 0);

    // Backpressure: three stalled cycles, skid takes one extra beat.
    drive(1'b1, 32'h20, 1'b0);
    chk("bp.s.occupancy", s_occ, 2);
    chk("bp.s.up_ready", s_up_ready, 0);
    chk("bp.s.dn_addr", s_dn_addr, 32'h1c);
    chk("bp.p.occupancy", p_occ, 1);
    drive(1'b1, 32'h20, 1'b0);
    drive(1'b1, 32'h20, 1'b0);
    chk("bp.s.stall_cnt", s_stall, 3);
    chk("bp.p.stall_cnt", p_stall, 3);
    drive(1'b1, 32'h20, 1'b1);
    chk("bp.s.drain_addr", s_dn_addr, 32'h20);
    chk("bp.s.drain_occ", s_occ, 1);
    chk("bp.p.drain_addr", p_dn_addr, 32'h20);
    drive(1'b1, 32'h24, 1'b1);
    drive(1'b1, 32'h28, 1'b1);
    chk("bp.s.resume_addr", s_dn_addr, 32'h28);

    // Flush while holding two entries with a beat offered.
    drive(1'b1, 32'h2c, 1'b0);
    chk("fl.s.occupancy_pre", s_occ, 2);
    flush = 1'b1;
    drive(1'b1, 32'h30, 1'b0);
    flush = 1'b0;
    chk("fl.s.dn_valid", s_dn_valid, 0);
    chk("fl.s.occupancy", s_occ, 0);
    chk("fl.s.up_ready", s_up_ready, 1);
    chk("fl.p.dn_valid", p_dn_valid, 0);
    drive(1'b1, 32'h34, 1'b1);
    chk("fl.s.next_addr", s_dn_addr, 32'h34);
    drive(1'b1, 32'h38, 1'b1);
    chk("fl.s.stall_cnt", s_stall, 5);
    chk("fl.p.stall_cnt", p_stall, 5);

    // dn_ready toggling 0,1: each address held for the pair.
    for (int k = 0; k < 4; k++) begin
      a = AW'(32'h3c + 4 * k);
      drive(1'b1, a, 1'b0);
      drive(1'b1, a, 1'b1);
      chk("tog.s.dn_addr", s_dn_addr, a);
      chk("tog.p.dn_addr", p_dn_addr, a);
    end
    drive(1'b0, '0, 1'b1);
    chk("tog.s.stall_cnt", s_stall, 9);
    chk("tog.p.stall_cnt", p_stall, 9);
    chk("tog.p.occupancy", p_occ, 0);

    // Saturation of the 4-bit counter; flush leaves it alone.
    drive(1'b1, 32'h80, 1'b1);
    repeat (20) drive(1'b0, '0, 1'b0);
    chk("sat.s.stall_cnt", s_stall, 15);
    chk("sat.p.stall_cnt", p_stall, 29);
    flush = 1'b1;
    drive(1'b0, '0, 1'b0);
    flush = 1'b0;
    chk("sat.s.after_flush", s_stall, 15);
    chk("sat.p.after_flush", p_stall, 30);

    // Reset with two entries held.
    drive(1'b1, 32'h90, 1'b0);
    drive(1'b1, 32'h94, 1'b0);
    chk("mrst.s.occupancy_pre", s_occ, 2);
    chk("mrst.p.occupancy_pre", p_occ, 1);
    rst = 1'b1;
    drive(1'b1, 32'h98, 1'b0);
    rst = 1'b0;
    chk("mrst.s.dn_valid", s_dn_valid, 0);
    chk("mrst.s.occupancy", s_occ, 0);
    chk("mrst.s.stall_cnt", s_stall, 0);
    chk("mrst.s.up_ready", s_up_ready, 1);
    chk("mrst.p.stall_cnt", p_stall, 0);
    drive(1'b1, 32'h100, 1'b1);
    chk("mrst.s.first_addr", s_dn_addr, 32'h100);
    chk("mrst.s.first_data", s_dn_data, {~32'h100, 32'h100});
    chk("mrst.p.first_addr", p_dn_addr, 32'h100);
    drive(1'b0, '0, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
